// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus for the edge-capturing input PIO.
interface pio_in_edge_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_in_edge_irq.sv
// Input PIO with per-bit synchroniser, optional debounce, selectable edge
// capture, interrupt mask and a registered level interrupt.
// Register map: 0 DATA (RO), 1 CONTROL edge select, 2 IRQMASK, 3 EDGECAP (RW1C).
module pio_in_edge_irq #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}},
    parameter logic [1:0]       EDGE_MODE_RESET = 2'd1
) (
    input  logic              clk,
    input  logic              reset,
    pio_in_edge_irq_if.slave  bus,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] mask;
    logic [1:0]       edge_sel;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // Two-flop synchroniser; resets to the idle level so release makes no edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        // No debounce: the synchronised value is the accepted level
        always_comb stable = sync2;
    end else begin : g_debounce
        localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0]    cnt [WIDTH];
        logic [WIDTH-1:0] stable_q;

        // Per-bit stability counter; a level is accepted on the cycle the
        // mismatch has persisted for DEBOUNCE_CYCLES consecutive cycles
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
                stable_q <= RESET_LEVEL;
            end else begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (sync2[i] == stable_q[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        stable_q[i] <= sync2[i];
                        cnt[i]      <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end

        // Debounced level drives everything downstream
        always_comb stable = stable_q;
    end

    // Edge detection, write decode and read mux
    always_comb begin
        wr_en    = bus.chipselect & bus.write;
        rise     = stable & ~prev;
        fall     = ~stable & prev;
        set_bits = (rise & {WIDTH{edge_sel[0]}}) | (fall & {WIDTH{edge_sel[1]}});
        clr_bits = '0;
        if (wr_en && bus.address == 2'd3) clr_bits = bus.writedata[WIDTH-1:0];

        rd_mux = '0;
        case (bus.address)
            2'd0: rd_mux[WIDTH-1:0] = stable;
            2'd1: rd_mux[1:0]       = edge_sel;
            2'd2: rd_mux[WIDTH-1:0] = mask;
            default: rd_mux[WIDTH-1:0] = edgecap;
        endcase

        unused_wdata = ^bus.writedata;
    end

    // CONTROL and IRQMASK registers
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_sel <= EDGE_MODE_RESET;
            mask     <= '0;
        end else if (wr_en) begin
            if (bus.address == 2'd1) edge_sel <= bus.writedata[1:0];
            if (bus.address == 2'd2) mask     <= bus.writedata[WIDTH-1:0];
        end
    end

    // Edge capture: a new edge overrides a same-cycle write-one-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= RESET_LEVEL;
            edgecap <= '0;
        end else begin
            prev    <= stable;
            edgecap <= (edgecap & ~clr_bits) | set_bits;
        end
    end

    // Registered read data (pre-write state) and level interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            bus.readdata <= rd_mux;
            irq          <= |(edgecap & mask);
        end
    end

endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Parametrised Avalon-MM slave input PIO; successor to the single-bit key/switch input port.
- Per bit: 2-flop synchroniser, optional debounce, per-bit edge capture with selectable edge type, interrupt mask, level irq.
- Sits between board keys/switches and the Nios II data master; one instance per input group.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a new level; 0 bypasses debounce (synchronised value used directly).
- RESET_LEVEL, all ones (WIDTH bits), reset value of synchroniser and debounced registers; keys idle high.
- EDGE_MODE_RESET, 2'd1, reset value of edge-select field.

Ports:
- clk  input  1  system clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- address  input  2  Avalon word address.
- chipselect  input  1  slave select.
- write  input  1  write strobe, qualified by chipselect.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt to CPU.

Behaviour:
- Reset: synchronous, active-high; all state updates on posedge clk.
- Reset values:
  - readdata = 0, irq = 0, edge capture = 0, mask = 0.
  - Synchroniser stages and debounced value = RESET_LEVEL.
  - Debounce counters = 0; edge select = EDGE_MODE_RESET.
- Synchroniser: 2 flops per bit, no reset-induced edge.
- Debounce (DEBOUNCE_CYCLES > 0):
  - Independent counter per bit, width clog2(DEBOUNCE_CYCLES+1).
  - While sync bit != stable bit, counter increments; any cycle where they are equal clears it.
  - When counter reaches DEBOUNCE_CYCLES-1 with mismatch still present: stable bit <= sync bit, counter <= 0.
  - Input-to-stable latency = 2 + DEBOUNCE_CYCLES cycles.
- Debounce bypass (DEBOUNCE_CYCLES = 0): stable = sync stage 2; latency 2 cycles.
- Edge detect: prev <= stable every cycle.
  - rise = stable & ~prev; fall = ~stable & prev.
  - Edge select: 0 none, 1 rising, 2 falling, 3 both.
- Register map (32-bit; unused read bits return 0):
  - 0 DATA, RO: debounced value [WIDTH-1:0]; writes ignored.
  - 1 CONTROL, RW: [1:0] edge select; other bits ignored.
  - 2 IRQMASK, RW: [WIDTH-1:0] per-bit interrupt enable.
  - 3 EDGECAP, RW1C: captured edges; writing 1 clears that bit, writing 0 has no effect.
- Edge capture set/clear: bit sets on a selected edge. If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.
- Changing edge select does not clear EDGECAP.
- Read path:
  - readdata <= mux(address) every cycle (not gated by read); read latency 1.
  - Value returned is the state before any same-cycle write.
- irq: registered; irq <= |(EDGECAP & IRQMASK), so irq follows its cause by 1 cycle.
  - Clearing all masked capture bits drops irq on the following cycle.
- Mid-operation reset: all state returns to reset values, pending counts discarded, irq drops the cycle after reset is sampled.
- Writes with chipselect = 0 are ignored.

Test Plan:
- Reset and data read:
  - Stimulus: WIDTH=4, DEBOUNCE_CYCLES=0, in_port=4'b1010; hold reset 2 cycles, then read address 0.
  - Required: readdata=0 during reset; readdata=32'h0000000A from 3 cycles after release; irq=0 throughout.
- Debounce:
  - Stimulus: DEBOUNCE_CYCLES=8; bit0 glitches low for 5 cycles, then goes low and stays low.
  - Required: glitch rejected, DATA[0] stays 1; DATA[0]=0 exactly 10 cycles after the stable low begins.
- Edge mode and irq:
  - Stimulus: CONTROL=1, IRQMASK=4'b0001; falling then rising edge on bit0.
  - Required: falling edge ignored; rising edge sets EDGECAP=1 and irq=1 one cycle later.
  - Stimulus: CONTROL=3.
  - Required: both edges captured.
- RW1C clear:
  - Stimulus: EDGECAP=4'b0101; write 32'h1 to address 3.
  - Required: EDGECAP=4'b0100; irq=0 when mask=4'b0001.
  - Stimulus: same-cycle edge on bit0 and write of 1 to bit0.
  - Required: bit0 stays 1.
- Mask gating:
  - Stimulus: capture edge on bit2 with IRQMASK=0, then set IRQMASK=4'b0100.
  - Required: irq stays 0, then asserts the cycle after the mask write.
- Mid-operation reset:
  - Stimulus: irq=1 and a debounce count in progress; pulse reset 1 cycle.
  - Required: EDGECAP=0, IRQMASK=0, irq=0, DATA=4'hF, no spurious edge captured after release.
